alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Execute-entry pipeline register for the piRISC core, sitting directly upstream of `alu`. Captures a decoded instruction, resolves both ALU operands (register data, PC, or immediate) with EX and MEM forwarding, detects load-use hazards and inserts bubbles, and presents registered `a`, `b`, and opcode to the ALU under a valid/ready handshake.

## Interface
- `XLEN`, 32, datapath width
- `OP_WIDTH`, 4, ALU opcode width; values are the shared `ALUADD`…`ALUSLTU` defines
- `RA_WIDTH`, 5, register address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  squash held instruction and current input
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts this cycle
- `in_alu_op`  in  OP_WIDTH  ALU opcode
- `in_rs1`, `in_rs2`  in  RA_WIDTH  source registers
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data
- `in_uses_rs1`, `in_uses_rs2`  in  1  instruction reads that source
- `in_a_sel`  in  1  0: rs1, 1: pc
- `in_b_sel`  in  1  0: rs2, 1: imm
- `in_pc`, `in_imm`  in  XLEN  PC and sign-extended immediate
- `in_rd`  in  RA_WIDTH; `in_rd_we`  in  1; `in_is_load`  in  1
- `fwd_ex_data`  in  XLEN  ALU result of the held instruction (`alu.out`)
- `fwd_mem_rd`  in  RA_WIDTH; `fwd_mem_we`  in  1; `fwd_mem_data`  in  XLEN  result of instruction one stage ahead (load data for loads)
- `out_valid`  out  1; `out_ready`  in  1
- `out_alu_op`  out  OP_WIDTH; `out_a`, `out_b`  out  XLEN  to `alu`
- `out_store_data`  out  XLEN  forwarded rs2 value
- `out_pc`  out  XLEN; `out_rd`  out  RA_WIDTH; `out_rd_we`, `out_is_load`  out  1

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `load_use` = `out_valid && out_is_load && out_rd_we && out_rd!=0 && in_valid && ((in_uses_rs1 && in_rs1==out_rd) || (in_uses_rs2 && in_rs2==out_rd))`.
- `in_ready` = `!flush && !load_use && (!out_valid || out_ready)`; combinational.
- Source resolution per rs (rsN, dataN), priority high→low:
  - rsN==0 → `in_rsN_data` (no forwarding of x0)
  - EX hit: `out_valid && out_rd_we && !out_is_load && out_rd==rsN` → `fwd_ex_data`
  - MEM hit: `fwd_mem_we && fwd_mem_rd==rsN` → `fwd_mem_data`
  - else `in_rsN_data`
- `out_a` ← pc if `in_a_sel` else resolved rs1; `out_b` ← imm if `in_b_sel` else resolved rs2; `out_store_data` ← resolved rs2 always.
- Register update on each rising edge, in priority order:
  - `flush`: `out_valid`←0; other outputs hold
  - transfer in: all `out_*` loaded, `out_valid`←1
  - `load_use && out_ready`: `out_valid`←0 (bubble); input held upstream, accepted next cycle via MEM forward
  - `out_ready && !in_valid`: `out_valid`←0
  - otherwise hold.
- No internal FSM beyond `out_valid`; widths never change, no arithmetic besides compares.

## Timing
- Reset (async assert, sync use): `out_valid`=0, all other `out_*`=0 (`out_alu_op`=0); `in_ready`=1 after reset with `flush`=0.
- Latency: 1 cycle accept→`out_valid`; throughput 1/cycle with `out_ready`=1.
- Load-use: exactly one bubble cycle when downstream flows.
- Downstream stall (`out_ready`=0, `out_valid`=1): all `out_*` stable; `in_ready`=0.
- `flush` with `in_valid`: input dropped, not captured; `out_valid`=0 next cycle.
- `rst` mid-stream: outputs clear immediately, independent of `clk`.

## Test plan
- Reset: `rst`=1 mid-cycle → `out_valid`=0, `out_a`=`out_b`=0 before next edge; release → `in_ready`=1.
- Plain flow: ADD rs1=x1(0x5),rs2=x2(0x7), no hits → next cycle `out_a`=5, `out_b`=7, `out_alu_op`=`ALUADD`, `alu.out`=0xC.
- EX forward: held ADD rd=x3, `fwd_ex_data`=0xC; next SUB rs1=x3, `in_rs1_data`=0 → `out_a`=0xC; x3 with MEM hit 0x99 too → still 0xC.
- Load-use: held LW rd=x4; next ADD rs1=x4 → `in_ready`=0 one cycle, `out_valid`=0 bubble; then `fwd_mem_rd`=4, data 0xDEAD → `out_a`=0xDEAD.
- x0 / imm select: ADDI rs1=x0, `fwd_mem_rd`=0 we=1 data 0xFF, imm=0xFFFFFFFF → `out_a`=0, `out_b`=0xFFFFFFFF.
- Stall+flush: `out_ready`=0 for 3 cycles → `out_*` constant, `in_ready`=0; assert `flush` with `in_valid`=1 → `out_valid`=0 next cycle, input not captured.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Bundle between decode, the execute-entry register and the ALU. The stage
// sits on the slave side; decode, forwarding sources and the ALU drive the
// master side.
interface alu_operand_stage_if #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 4,
  parameter int RA_WIDTH = 5
);
  // squash control
  logic                flush;

  // decoded instruction from decode
  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] in_alu_op;
  logic [RA_WIDTH-1:0] in_rs1;
  logic [RA_WIDTH-1:0] in_rs2;
  logic [XLEN-1:0]     in_rs1_data;
  logic [XLEN-1:0]     in_rs2_data;
  logic                in_uses_rs1;
  logic                in_uses_rs2;
  logic                in_a_sel;
  logic                in_b_sel;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_imm;
  logic [RA_WIDTH-1:0] in_rd;
  logic                in_rd_we;
  logic                in_is_load;

  // forwarding sources
  logic [XLEN-1:0]     fwd_ex_data;
  logic [RA_WIDTH-1:0] fwd_mem_rd;
  logic                fwd_mem_we;
  logic [XLEN-1:0]     fwd_mem_data;

  // registered operands towards the ALU
  logic                out_valid;
  logic                out_ready;
  logic [OP_WIDTH-1:0] out_alu_op;
  logic [XLEN-1:0]     out_a;
  logic [XLEN-1:0]     out_b;
  logic [XLEN-1:0]     out_store_data;
  logic [XLEN-1:0]     out_pc;
  logic [RA_WIDTH-1:0] out_rd;
  logic                out_rd_we;
  logic                out_is_load;

  modport master (
    output flush,
    output in_valid, in_alu_op, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
    output in_uses_rs1, in_uses_rs2, in_a_sel, in_b_sel, in_pc, in_imm,
    output in_rd, in_rd_we, in_is_load,
    output fwd_ex_data, fwd_mem_rd, fwd_mem_we, fwd_mem_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_alu_op, out_a, out_b, out_store_data,
    input  out_pc, out_rd, out_rd_we, out_is_load
  );

  modport slave (
    input  flush,
    input  in_valid, in_alu_op, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
    input  in_uses_rs1, in_uses_rs2, in_a_sel, in_b_sel, in_pc, in_imm,
    input  in_rd, in_rd_we, in_is_load,
    input  fwd_ex_data, fwd_mem_rd, fwd_mem_we, fwd_mem_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_alu_op, out_a, out_b, out_store_data,
    output out_pc, out_rd, out_rd_we, out_is_load
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Execute-entry pipeline register for piRISC. Resolves both ALU operands with
// EX/MEM forwarding, stalls one cycle on a load-use dependency and presents
// registered a/b/opcode to the ALU under valid/ready.
module alu_operand_stage #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 4,
  parameter int RA_WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [OP_WIDTH-1:0] alu_op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [XLEN-1:0]     store_data;
    logic [XLEN-1:0]     pc;
    logic [RA_WIDTH-1:0] rd;
    logic                rd_we;
    logic                is_load;
  } payload_t;

  logic     out_valid_q, out_valid_d;
  payload_t payload_q, payload_d;

  logic            load_use;
  logic            xfer_in;
  logic            ex_fwd_ok;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // x0 never forwards; the held (EX) instruction beats the MEM instruction
  // because it is the younger producer.
  function automatic logic [XLEN-1:0] resolve(
    input logic [RA_WIDTH-1:0] rs,
    input logic [XLEN-1:0]     rf_data,
    input logic                ex_ok,
    input logic [RA_WIDTH-1:0] ex_rd,
    input logic [XLEN-1:0]     ex_data,
    input logic                mem_we,
    input logic [RA_WIDTH-1:0] mem_rd,
    input logic [XLEN-1:0]     mem_data
  );
    if (rs == '0)                    return rf_data;
    else if (ex_ok && ex_rd == rs)   return ex_data;
    else if (mem_we && mem_rd == rs) return mem_data;
    return rf_data;
  endfunction

  // Hazard detection, handshake and operand resolution.
  always_comb begin
    // A held load has no result yet, so it cannot feed the EX forward path.
    ex_fwd_ok = out_valid_q && payload_q.rd_we && !payload_q.is_load;

    load_use = out_valid_q && payload_q.is_load && payload_q.rd_we &&
               (payload_q.rd != '0) && bus.in_valid &&
               ((bus.in_uses_rs1 && bus.in_rs1 == payload_q.rd) ||
                (bus.in_uses_rs2 && bus.in_rs2 == payload_q.rd));

    bus.in_ready = !bus.flush && !load_use && (!out_valid_q || bus.out_ready);
    xfer_in      = bus.in_valid && bus.in_ready;

    rs1_val = resolve(bus.in_rs1, bus.in_rs1_data, ex_fwd_ok, payload_q.rd,
                      bus.fwd_ex_data, bus.fwd_mem_we, bus.fwd_mem_rd,
                      bus.fwd_mem_data);
    rs2_val = resolve(bus.in_rs2, bus.in_rs2_data, ex_fwd_ok, payload_q.rd,
                      bus.fwd_ex_data, bus.fwd_mem_we, bus.fwd_mem_rd,
                      bus.fwd_mem_data);
  end

  // Next-state of the output register, highest-priority event first.
  always_comb begin
    // NOTE: every _d starts from its held value so no branch leaves it unassigned and infers a latch.
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (xfer_in) begin
      out_valid_d          = 1'b1;
      payload_d.alu_op     = bus.in_alu_op;
      payload_d.a          = bus.in_a_sel ? bus.in_pc  : rs1_val;
      payload_d.b          = bus.in_b_sel ? bus.in_imm : rs2_val;
      payload_d.store_data = rs2_val;
      payload_d.pc         = bus.in_pc;
      payload_d.rd         = bus.in_rd;
      payload_d.rd_we      = bus.in_rd_we;
      payload_d.is_load    = bus.in_is_load;
    end else if (load_use && bus.out_ready) begin
      // Bubble: the load leaves, the dependent waits for its MEM forward.
      out_valid_d = 1'b0;
    end else if (bus.out_ready && !bus.in_valid) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset clears the ALU view immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_alu_op     = payload_q.alu_op;
  assign bus.out_a          = payload_q.a;
  assign bus.out_b          = payload_q.b;
  assign bus.out_store_data = payload_q.store_data;
  assign bus.out_pc         = payload_q.pc;
  assign bus.out_rd         = payload_q.rd;
  assign bus.out_rd_we      = payload_q.rd_we;
  assign bus.out_is_load    = payload_q.is_load;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Expected transfers are queued when
// stimulus is issued; a monitor pops and compares each one as it leaves.
module tb_alu_operand_stage;

  localparam logic [3:0] ALUADD = 4'd0;
  localparam logic [3:0] ALUSUB = 4'd1;
  localparam logic [3:0] ALUAND = 4'd2;
  localparam logic [3:0] ALUOR  = 4'd3;
  localparam logic [3:0] ALUXOR = 4'd4;
  localparam logic [3:0] ALUSRL = 4'd5;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_operand_stage_if #(.XLEN(32), .OP_WIDTH(4), .RA_WIDTH(5)) bus ();

  alu_operand_stage #(.XLEN(32), .OP_WIDTH(4), .RA_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [4:0] rs1, input logic [31:0] d1, input logic u1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic u2,
                       input logic asel, input logic bsel,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic we, input logic ld);
    bus.in_valid    = 1'b1;
    bus.in_alu_op   = op;
    bus.in_rs1      = rs1;
    bus.in_rs1_data = d1;
    bus.in_uses_rs1 = u1;
    bus.in_rs2      = rs2;
    bus.in_rs2_data = d2;
    bus.in_uses_rs2 = u2;
    bus.in_a_sel    = asel;
    bus.in_b_sel    = bsel;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
    bus.in_rd_we    = we;
    bus.in_is_load  = ld;
  endtask

  task automatic expect_out(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] sd,
                            input logic [31:0] pc, input logic [4:0] rd,
                            input logic we, input logic ld);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.sd = sd; e.pc = pc; e.rd = rd; e.we = we; e.ld = ld;
    exp_q.push_back(e);
  endtask

  // Monitor: every output that will transfer on the coming edge is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_alu_op",     32'(bus.out_alu_op), 32'(e.op));
          check("out_a",          bus.out_a,           e.a);
          check("out_b",          bus.out_b,           e.b);
          check("out_store_data", bus.out_store_data,  e.sd);
          check("out_pc",         bus.out_pc,          e.pc);
          check("out_rd",         32'(bus.out_rd),     32'(e.rd));
          check("out_rd_we",      32'(bus.out_rd_we),  32'(e.we));
          check("out_is_load",    32'(bus.out_is_load), 32'(e.ld));
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
    bus.fwd_ex_data  = '0;
    bus.fwd_mem_rd   = '0;
    bus.fwd_mem_we   = 1'b0;
    bus.fwd_mem_data = '0;
    drive(ALUADD, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    bus.in_valid     = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_a",      bus.out_a,           32'd0);
    check("rst_out_b",      bus.out_b,           32'd0);
    check("rst_out_alu_op", 32'(bus.out_alu_op), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Plain flow: ADD x1(5), x2(7) -> x3
    drive(ALUADD, 5'd1, 32'h5, 1, 5'd2, 32'h7, 1, 0, 0, 32'h100, 0, 5'd3, 1, 0);
    expect_out(ALUADD, 32'h5, 32'h7, 32'h7, 32'h100, 5'd3, 1, 0);
    @(negedge clk);
    check("plain_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // EX forward beats a simultaneous MEM hit on x3
    drive(ALUSUB, 5'd3, 32'h0, 1, 5'd1, 32'h5, 1, 0, 0, 32'h104, 0, 5'd5, 1, 0);
    bus.fwd_ex_data  = 32'hC;
    bus.fwd_mem_we   = 1'b1;
    bus.fwd_mem_rd   = 5'd3;
    bus.fwd_mem_data = 32'h99;
    expect_out(ALUSUB, 32'hC, 32'h5, 32'h5, 32'h104, 5'd5, 1, 0);
    step();

    // MEM forward alone on rs2, EX producer (x5) unrelated
    drive(ALUAND, 5'd6, 32'h10, 1, 5'd7, 32'h20, 1, 0, 0, 32'h108, 0, 5'd8, 1, 0);
    bus.fwd_ex_data  = 32'hAAAA;
    bus.fwd_mem_rd   = 5'd7;
    bus.fwd_mem_data = 32'h77;
    expect_out(ALUAND, 32'h10, 32'h77, 32'h77, 32'h108, 5'd8, 1, 0);
    step();

    // LW x4 <- 4(x2)
    drive(ALUADD, 5'd2, 32'h1000, 1, 5'd0, 32'h0, 0, 0, 1, 32'h10C, 32'h4, 5'd4, 1, 1);
    bus.fwd_mem_we = 1'b0;
    expect_out(ALUADD, 32'h1000, 32'h4, 32'h0, 32'h10C, 5'd4, 1, 1);
    step();

    // Dependent ADD x9 = x4 + x0: one bubble, then MEM forward
    drive(ALUADD, 5'd4, 32'h0, 1, 5'd0, 32'h0, 1, 0, 0, 32'h110, 0, 5'd9, 1, 0);
    @(negedge clk);
    check("load_use_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.fwd_mem_we   = 1'b1;
    bus.fwd_mem_rd   = 5'd4;
    bus.fwd_mem_data = 32'hDEAD;
    expect_out(ALUADD, 32'hDEAD, 32'h0, 32'h0, 32'h110, 5'd9, 1, 0);
    @(negedge clk);
    check("bubble_out_valid", 32'(bus.out_valid), 32'd0);
    check("bubble_in_ready",  32'(bus.in_ready),  32'd1);
    step();

    // ADDI x10 = x0 + -1 with a MEM writer claiming x0
    drive(ALUADD, 5'd0, 32'h0, 1, 5'd0, 32'h0, 0, 0, 1, 32'h114, 32'hFFFF_FFFF, 5'd10, 1, 0);
    bus.fwd_mem_rd   = 5'd0;
    bus.fwd_mem_data = 32'hFF;
    expect_out(ALUADD, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h114, 5'd10, 1, 0);
    step();

    // Downstream stall for three cycles with a new instruction waiting
    drive(ALUOR, 5'd11, 32'h1234, 1, 5'd12, 32'h5678, 1, 0, 0, 32'h118, 0, 5'd13, 1, 0);
    bus.fwd_mem_we = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_a",     bus.out_a,          32'h0);
      check("stall_out_b",     bus.out_b,          32'hFFFF_FFFF);
      check("stall_out_pc",    bus.out_pc,         32'h114);
      step();
    end

    // Flush while stalled with in_valid high: ADDI squashed, OR not captured
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    void'(exp_q.pop_back());
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid",  32'(bus.out_valid),  32'd0);
    check("flush_out_pc",     bus.out_pc,          32'h114);
    check("flush_out_alu_op", 32'(bus.out_alu_op), 32'(ALUADD));
    step();

    // Single XOR, then idle input drains out_valid
    drive(ALUXOR, 5'd1, 32'h3, 1, 5'd2, 32'h5, 1, 0, 0, 32'h200, 0, 5'd14, 1, 0);
    expect_out(ALUXOR, 32'h3, 32'h5, 32'h5, 32'h200, 5'd14, 1, 0);
    step();
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Asynchronous reset with a held output
    bus.out_ready = 1'b0;
    drive(ALUSRL, 5'd15, 32'hABCD, 1, 5'd16, 32'h2, 1, 0, 0, 32'h300, 0, 5'd17, 1, 0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_a", bus.out_a, 32'hABCD);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("async_rst_out_a",      bus.out_a,           32'd0);
    check("async_rst_out_b",      bus.out_b,           32'd0);
    check("async_rst_out_alu_op", 32'(bus.out_alu_op), 32'd0);
    check("async_rst_out_pc",     bus.out_pc,          32'd0);
    step();
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Everything queued must have left, bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
